check_result: RTL and testbench

Result checker at the far end of the stimulus path. Pops one expected-result record from the CHECK_FIFO and one captured DUT output word from the RESULT_FIFO. Compares them under the output bitmask received over the STIM<=>CHECK command interface. Writes a 5-word failure record for every mismatching vector into a result area in external memory over an Avalon-MM write master.

---
 rtl/check_result_if.sv | 15 +
 rtl/check_result.sv | 153 +++++++++++++++
 tb/tb_check_result.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/check_result_if.sv
// Avalon-MM write-master bus used by the result checker to store failure records.
interface check_result_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;

    modport master (output address, byteenable, write, writedata, input waitrequest);
    modport slave  (input address, byteenable, write, writedata, output waitrequest);
endinterface

// File: rtl/check_result.sv
// Pops expected/received vector pairs, compares them under a mask and writes
// a 5-word failure record to the result area for every mismatch.
module check_result #(
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    BE_WIDTH    = DATA_WIDTH / 8,
    parameter int                    STF_WIDTH   = 24,
    parameter int                    CHF_WIDTH   = STF_WIDTH + ADDR_WIDTH,
    parameter int                    SCC_WIDTH   = 5,
    parameter int                    SCD_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] RESULT_BASE = 20'h80000,
    parameter logic [ADDR_WIDTH-1:0] RES_WORDS   = 20'h10000,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CHF_WIDTH-1:0] cfifo_data,
    output logic                 cfifo_rdreq,
    input  logic                 cfifo_rdempty,
    input  logic [STF_WIDTH-1:0] rfifo_data,
    output logic                 rfifo_rdreq,
    input  logic                 rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0] sc_cmd,
    input  logic [SCD_WIDTH-1:0] sc_data,
    output logic                 sc_ready,
    check_result_if.master       mem,
    output logic [CNT_WIDTH-1:0] vec_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic                 overflow,
    output logic                 idle
);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_COMPARE, S_WRITE} state_t;

    localparam logic [SCC_WIDTH-1:0] CMD_SET_MASK = SCC_WIDTH'(1);

    state_t                r_state;
    logic [STF_WIDTH-1:0]  r_mask;
    logic [STF_WIDTH-1:0]  r_expected;
    logic [STF_WIDTH-1:0]  r_received;
    logic [ADDR_WIDTH-1:0] r_vec_addr;
    logic [CNT_WIDTH-1:0]  r_vec_count;
    logic [CNT_WIDTH-1:0]  r_fail_count;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic                  r_overflow;
    logic [2:0]            r_idx;

    logic w_cmd_set;
    logic w_pop;
    logic w_fail;
    logic w_room;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rec_word(
        input logic [2:0]            idx,
        input logic [ADDR_WIDTH-1:0] va,
        input logic [STF_WIDTH-1:0]  rcv,
        input logic [STF_WIDTH-1:0]  exp
    );
        case (idx)
            3'd0:    return va[15:0];
            3'd1:    return {va[19:16], 4'h0, rcv[23:16]};
            3'd2:    return rcv[15:0];
            3'd3:    return {8'h00, exp[23:16]};
            default: return exp[15:0];
        endcase
    endfunction

    // A command or start in IDLE blocks the pop for that cycle.
    assign w_cmd_set   = (r_state == S_IDLE) && (sc_cmd == CMD_SET_MASK);
    assign w_pop       = (r_state == S_IDLE) && !w_cmd_set && !start &&
                         !cfifo_rdempty && !rfifo_rdempty;
    assign w_fail      = |((r_received ^ r_expected) & r_mask);
    assign w_room      = (r_wptr <= RES_WORDS - ADDR_WIDTH'(5));

    assign cfifo_rdreq = w_pop;
    assign rfifo_rdreq = w_pop;
    assign sc_ready    = (r_state == S_IDLE);
    assign idle        = (r_state == S_IDLE) && cfifo_rdempty && rfifo_rdempty;
    assign vec_count   = r_vec_count;
    assign fail_count  = r_fail_count;
    assign overflow    = r_overflow;

    assign mem.byteenable = {BE_WIDTH{1'b1}};
    assign mem.write      = (r_state == S_WRITE);
    assign mem.address    = RESULT_BASE + r_wptr;
    assign mem.writedata  = (r_state == S_WRITE) ?
                            rec_word(r_idx, r_vec_addr, r_received, r_expected) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mask       <= '1;
            r_vec_count  <= '0;
            r_fail_count <= '0;
            r_wptr       <= '0;
            r_overflow   <= 1'b0;
            r_idx        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_set) r_mask <= STF_WIDTH'(sc_data);
                    if (start) begin
                        r_vec_count  <= '0;
                        r_fail_count <= '0;
                        r_wptr       <= '0;
                        r_overflow   <= 1'b0;
                    end
                    if (w_pop) r_state <= S_LATCH;
                end
                S_LATCH: r_state <= S_COMPARE;
                S_COMPARE: begin
                    r_vec_count <= sat_inc(r_vec_count);
                    if (w_fail) begin
                        r_fail_count <= sat_inc(r_fail_count);
                        // A record is only started when all five words fit.
                        if (w_room) begin
                            r_idx   <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_overflow <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (!mem.waitrequest) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == 3'd4) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO read data is valid the cycle after the pop.
    always_ff @(posedge clock) begin
        if (r_state == S_LATCH) begin
            r_expected <= cfifo_data[CHF_WIDTH-1:ADDR_WIDTH];
            r_vec_addr <= cfifo_data[ADDR_WIDTH-1:0];
            r_received <= rfifo_data;
        end
    end

endmodule

// File: tb/tb_check_result.sv
// Randomized bench for check_result against a transaction-level reference model.
module tb_check_result;
    localparam int              AW = 20;
    localparam int              DW = 16;
    localparam int              SW = 24;
    localparam int              CW = SW + AW;
    localparam int              RW = 10;
    localparam logic [AW-1:0]   RB = 20'h80000;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   cfifo_data = '0;
    logic            cfifo_rdreq;
    logic            cfifo_rdempty = 1'b1;
    logic [SW-1:0]   rfifo_data = '0;
    logic            rfifo_rdreq;
    logic            rfifo_rdempty = 1'b1;
    logic [4:0]      sc_cmd = '0;
    logic [23:0]     sc_data = '0;
    logic            sc_ready;
    logic [15:0]     vec_count;
    logic [15:0]     fail_count;
    logic            overflow;
    logic            idle;

    check_result_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    check_result #(.RES_WORDS(20'd10)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
        .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
        .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
        .mem(mem_if.master),
        .vec_count(vec_count), .fail_count(fail_count), .overflow(overflow), .idle(idle)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [23:0]   m_mask;
    int            m_vec, m_fail, m_wptr;
    logic          m_ovf;
    logic [35:0]   exp_wr[$];
    logic [35:0]   got_wr[$];
    logic [CW-1:0] cq[$];
    logic [SW-1:0] rq[$];
    logic          pend;
    logic [CW-1:0] pc;
    logic [SW-1:0] pr;
    logic          cmd_acc;
    int            cyc, pop_cyc, stall_left;
    logic [AW-1:0] stall_addr;
    int            nchk, npass;

    logic [35:0] spec_tbl [5] = '{36'h80000ABCD, 36'h800013012, 36'h800023457,
                                  36'h800030012, 36'h800043456};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mask = '1; m_vec = 0; m_fail = 0; m_wptr = 0; m_ovf = 1'b0;
        exp_wr.delete(); cq.delete(); rq.delete();
        pend = 1'b0; cmd_acc = 1'b0; stall_left = 0;
    endtask

    task automatic model_vec(input logic [SW-1:0] e, input logic [AW-1:0] va, input logic [SW-1:0] r);
        logic [DW-1:0] w [5];
        if (m_vec < 65535) m_vec++;
        if (((r ^ e) & m_mask) != 0) begin
            if (m_fail < 65535) m_fail++;
            if (m_wptr + 5 <= RW) begin
                w[0] = va[15:0];
                w[1] = {va[19:16], 4'h0, r[23:16]};
                w[2] = r[15:0];
                w[3] = {8'h00, e[23:16]};
                w[4] = e[15:0];
                for (int k = 0; k < 5; k++) exp_wr.push_back({RB + AW'(m_wptr + k), w[k]});
                m_wptr += 5;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (cmd_acc) begin sc_cmd = '0; cmd_acc = 1'b0; end
        if (pend) begin cfifo_data = pc; rfifo_data = pr; pend = 1'b0; end
        cfifo_rdempty = (cq.size() == 0);
        rfifo_rdempty = (rq.size() == 0);
        mem_if.waitrequest = 1'b0;
        if (mem_if.write && stall_left > 0 && mem_if.address == stall_addr) begin
            mem_if.waitrequest = 1'b1;
            stall_left--;
        end
        #1;
        if (mem_if.write) begin
            if (exp_wr.size() == 0) check("write_expected", 64'(exp_wr.size()), 64'd1);
            else begin
                check(mem_if.waitrequest ? "held_word" : "write_word",
                      64'({mem_if.address, mem_if.writedata}), 64'(exp_wr[0]));
                if (!mem_if.waitrequest) begin
                    got_wr.push_back({mem_if.address, mem_if.writedata});
                    void'(exp_wr.pop_front());
                end
            end
        end
        if (cfifo_rdreq || rfifo_rdreq) begin
            check("rdreq_pair", 64'({cfifo_rdreq, rfifo_rdreq}), 64'd3);
            check("pop_nonempty", 64'(cq.size() > 0 && rq.size() > 0), 64'd1);
            if (cq.size() > 0 && rq.size() > 0) begin
                pc = cq.pop_front();
                pr = rq.pop_front();
                pend = 1'b1;
                pop_cyc = cyc;
                model_vec(pc[CW-1:AW], pc[AW-1:0], pr);
            end
        end
        if (sc_cmd == 5'd1 && sc_ready) begin m_mask = sc_data; cmd_acc = 1'b1; end
    endtask

    task automatic check_counts();
        check("vec_count", 64'(vec_count), 64'(m_vec));
        check("fail_count", 64'(fail_count), 64'(m_fail));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("writes_done", 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic wait_idle(output int lat);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            step();
            n++;
            ok = sc_ready && cq.size() == 0 && rq.size() == 0 && !pend && sc_cmd == 0;
        end
        check("reach_idle", 64'(ok), 64'd1);
        check("idle_out", 64'(idle), 64'd1);
        lat = cyc - pop_cyc;
        check_counts();
    endtask

    task automatic push_vec(input logic [SW-1:0] e, input logic [AW-1:0] va, input logic [SW-1:0] r);
        cq.push_back({e, va});
        rq.push_back(r);
    endtask

    task automatic send_cmd(input logic [23:0] mask);
        int n;
        sc_data = mask;
        sc_cmd = 5'd1;
        n = 0;
        while (!cmd_acc && n < 100) begin step(); n++; end
        check("cmd_accepted", 64'(cmd_acc), 64'd1);
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_vec = 0; m_fail = 0; m_wptr = 0; m_ovf = 1'b0;
        step();
        check_counts();
    endtask

    initial begin
        int            lat, n, nv;
        logic [SW-1:0] e, r;
        logic [AW-1:0] va;
        nchk = 0; npass = 0; cyc = 0; pop_cyc = 0;
        mem_if.waitrequest = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step();
        check("rst_rdreq", 64'({cfifo_rdreq, rfifo_rdreq}), 64'd0);
        check("rst_write", 64'(mem_if.write), 64'd0);
        check("rst_wdata", 64'(mem_if.writedata), 64'd0);
        check("rst_be", 64'(mem_if.byteenable), 64'd3);
        check("rst_ready", 64'(sc_ready), 64'd1);
        check_counts();
        reset_n = 1'b1;
        step();

        // Matching vector, full mask
        push_vec(24'h00A5A5, 20'h00010, 24'h00A5A5);
        wait_idle(lat);
        check("pass_latency", 64'(lat), 64'd3);

        // Low-byte mask: pass then fail
        send_cmd(24'h0000FF);
        push_vec(24'h123456, 20'h00020, 24'hFFFF56);
        wait_idle(lat);
        check("masked_pass_latency", 64'(lat), 64'd3);
        push_vec(24'h123456, 20'h3ABCD, 24'h123457);
        wait_idle(lat);
        check("fail_latency", 64'(lat), 64'd8);
        check("rec_count", 64'(got_wr.size()), 64'd5);
        for (int i = 0; i < 5 && i < got_wr.size(); i++) check("spec_record", 64'(got_wr[i]), 64'(spec_tbl[i]));

        // Stall on word 2
        pulse_start();
        stall_addr = RB + 20'd2;
        stall_left = 3;
        push_vec(24'h000001, 20'h00444, 24'h000002);
        wait_idle(lat);
        check("stall_latency", 64'(lat), 64'd11);
        check("stall_used", 64'(stall_left), 64'd0);

        // Area fills: second record at 5..9, third vector overflows
        push_vec(24'h000010, 20'h00555, 24'h000011);
        push_vec(24'h000020, 20'h00666, 24'h000021);
        wait_idle(lat);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_fails", 64'(fail_count), 64'd3);
        check("last_addr", 64'(got_wr[got_wr.size()-1][35:16]), 64'(RB + 20'd9));

        // One FIFO empty, then command during WRITE
        pulse_start();
        cq.push_back({24'h000AAA, 20'h00777});
        repeat (3) step();
        check("no_rdreq", 64'(cfifo_rdreq), 64'd0);
        check("stay_idle", 64'(sc_ready), 64'd1);
        check("idle_flag_busy", 64'(idle), 64'd0);
        rq.push_back(24'h000AAB);
        n = 0;
        while (!mem_if.write && n < 20) begin step(); n++; end
        check("write_started", 64'(mem_if.write), 64'd1);
        sc_data = 24'h0F00FF;
        sc_cmd = 5'd1;
        step();
        check("ready_in_write", 64'(sc_ready), 64'd0);
        wait_idle(lat);

        // Reset during WRITE word 1
        push_vec(24'h000000, 20'h00888, 24'h000001);
        n = 0;
        while (!mem_if.write && n < 20) begin step(); n++; end
        step();
        reset_n = 1'b0;
        #1;
        check("rst_drops_write", 64'(mem_if.write), 64'd0);
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_rst_ready", 64'(sc_ready), 64'd1);
        check_counts();
        n = got_wr.size();
        push_vec(24'h000000, 20'h00999, 24'h100000);
        wait_idle(lat);
        check("post_rst_record", 64'(got_wr.size() - n), 64'd5);
        if (got_wr.size() > n) check("post_rst_addr", 64'(got_wr[n][35:16]), 64'(RB));

        // Randomized batches
        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 1) == 1) pulse_start();
            if ($urandom_range(0, 2) == 0) send_cmd(24'($urandom));
            stall_left = $urandom_range(0, 3);
            stall_addr = RB + AW'(m_wptr + $urandom_range(0, 4));
            nv = $urandom_range(1, 3);
            for (int i = 0; i < nv; i++) begin
                e  = 24'($urandom);
                va = 20'($urandom);
                r  = ($urandom_range(0, 1) == 1) ? e : (e ^ (24'd1 << $urandom_range(0, 23)));
                push_vec(e, va, r);
            end
            wait_idle(lat);
            stall_left = 0;
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", nchk);
        $fatal(1);
    end

endmodule
